scan_sequencer_sar: RTL and testbench

Synchronous 3-bit code sequencer that sits directly upstream of the 3-to-8 decoder and drives its `in[0:2]` input. It steps the code through up, down, one-shot or ping-pong sequences, holding each code for a programmable dwell. A start/stop handshake controls it, and it reports busy, wrap and done status, so a scan controller or test fixture can sweep all eight decoder outputs without hand-driven stimulus.

---
 rtl/scan_sequencer_sar_pkg.sv | 24 ++
 rtl/scan_sequencer_sar_dwell_timer.sv | 38 +++
 rtl/scan_sequencer_sar.sv | 174 +++++++++++++++++
 tb/tb_scan_sequencer_sar.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_sequencer_sar_pkg.sv
// Shared constants for the 3-bit scan code sequencer: FSM states, scan
// modes and the code range swept on the downstream 3-to-8 decoder.
package scan_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_PINGPONG = 2'b11;

  localparam logic [2:0] CODE_MIN = 3'b000;
  localparam logic [2:0] CODE_MAX = 3'b111;

  // Down-counting scans start from the top code, all others from the bottom.
  function automatic logic [2:0] first_code(input logic [1:0] mode);
    return (mode == MODE_DOWN) ? CODE_MAX : CODE_MIN;
  endfunction

endpackage

// File: rtl/scan_sequencer_sar_dwell_timer.sv
// Dwell counter: counts 0..limit while enabled and flags the final cycle.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] limit,
  output logic               tick
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  // Last cycle of the dwell window; unsigned compare.
  assign tick = (count_q == limit);

  // Next count: clear wins, then wrap to zero on tick, else increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/scan_sequencer_sar.sv
// Scan code sequencer driving the in[0:2] port of a 3-to-8 decoder.
// Steps a 3-bit code up, down, once, or back and forth, holding each
// code for dwell+1 cycles, with start/stop control and status pulses.
module scan_sequencer_sar
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [0:2]         code_out,
  output logic               code_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  state_e             state_q, state_d;
  logic [2:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic [1:0]         mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_up_q, dir_up_d;

  logic               tmr_clr;
  logic               tmr_en;
  logic               tmr_tick;
  logic [2:0]         code_inc;
  logic [2:0]         code_dec;

  dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (dwell_q),
    .tick  (tmr_tick)
  );

  assign code_inc = code_q + 3'd1;
  assign code_dec = code_q - 3'd1;

  // Next-state and next-output logic; stop outranks any step in RUN.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    mode_d   = mode_q;
    dwell_d  = dwell_q;
    dir_up_d = dir_up_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start && !stop) begin
          state_d  = RUN;
          mode_d   = mode;
          dwell_d  = dwell;
          code_d   = first_code(mode);
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          dir_up_d = 1'b1;
          tmr_clr  = 1'b1;
        end
      end

      RUN: begin
        tmr_en = !stop;
        if (stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (tmr_tick) begin
          case (mode_q)
            MODE_UP: begin
              code_d = code_inc;
              wrap_d = (code_q == CODE_MAX);
            end
            MODE_DOWN: begin
              code_d = code_dec;
              wrap_d = (code_q == CODE_MIN);
            end
            MODE_ONESHOT: begin
              if (code_q == CODE_MAX) begin
                state_d = DONE;
                done_d  = 1'b1;
                valid_d = 1'b0;
                busy_d  = 1'b0;
              end else begin
                code_d = code_inc;
              end
            end
            default: begin
              // Ping-pong: the end codes are shown once, so the direction
              // flips as soon as an end code is reached.
              if (dir_up_q) begin
                code_d = code_inc;
                if (code_inc == CODE_MAX) begin
                  wrap_d   = 1'b1;
                  dir_up_d = 1'b0;
                end
              end else begin
                code_d = code_dec;
                if (code_dec == CODE_MIN) begin
                  wrap_d   = 1'b1;
                  dir_up_d = 1'b1;
                end
              end
            end
          endcase
        end
      end

      DONE: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, code, status and latched configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      code_q   <= CODE_MIN;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= MODE_UP;
      dwell_q  <= '0;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      dwell_q  <= dwell_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign busy       = busy_q;
  assign wrap       = wrap_q;
  assign done       = done_q;

endmodule

// File: tb/tb_scan_sequencer_sar.sv
// Self-checking bench for scan_sequencer_sar feeding a 3-to-8 decoder.
module tb_scan_sequencer_sar;

  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic [0:2]         code_out;
  logic               code_valid;
  logic               busy;
  logic               wrap;
  logic               done;

  logic [2:0]         code_num;
  logic [7:0]         dec_out;

  int n_checks;
  int n_fail;

  typedef struct {
    int code;
    int valid;
    int busy;
    int wrap;
    int done;
  } exp_t;

  typedef struct {
    int mode;
    int dwell;
    int ncyc;
    int exp_stop_code;
  } vec_t;

  scan_sequencer_sar #(
    .DWELL_W(DWELL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .dwell      (dwell),
    .code_out   (code_out),
    .code_valid (code_valid),
    .busy       (busy),
    .wrap       (wrap),
    .done       (done)
  );

  // Downstream 3-to-8 decoder: in[0] is the MSB.
  assign code_num = code_out;
  assign dec_out  = 8'b1 << code_num;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " code"}, int'(code_num), e.code);
    check({tag, " valid"}, int'(code_valid), e.valid);
    check({tag, " busy"}, int'(busy), e.busy);
    check({tag, " wrap"}, int'(wrap), e.wrap);
    check({tag, " done"}, int'(done), e.done);
    if (code_valid) begin
      check({tag, " onehot"}, int'($onehot(dec_out)), 1);
      check({tag, " decode"}, int'(dec_out), 1 << e.code);
    end
  endtask

  // Expected outputs t cycles after the start is accepted, from the
  // sequence definitions: step index s, code derived arithmetically.
  function automatic exp_t model(input int m, input int d, input int t);
    exp_t e;
    int p, s, ph;
    bit first;
    p = d + 1;
    s = t / p;
    first = (t % p) == 0;
    e.valid = 1; e.busy = 1; e.wrap = 0; e.done = 0;
    case (m)
      0: begin
        e.code = s % 8;
        e.wrap = int'(first && s > 0 && e.code == 0);
      end
      1: begin
        e.code = 7 - (s % 8);
        e.wrap = int'(first && s > 0 && e.code == 7);
      end
      2: begin
        if (s < 8) begin
          e.code = s;
        end else begin
          e.code = 7; e.valid = 0; e.busy = 0;
          e.done = int'(t == 8 * p);
        end
      end
      default: begin
        ph = s % 14;
        e.code = (ph <= 7) ? ph : 14 - ph;
        e.wrap = int'(first && s > 0 && (e.code == 0 || e.code == 7));
      end
    endcase
    return e;
  endfunction

  // Start a scan, follow it for n cycles against the model, then stop it.
  task automatic run_seq(input int m, input int d, input int n, output int last_code);
    exp_t e;
    exp_t idle_e;
    @(negedge clk);
    start = 1'b1; mode = 2'(m); dwell = DWELL_W'(d);
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); dwell = DWELL_W'($urandom);
    last_code = 0;
    for (int t = 0; t < n; t++) begin
      e = model(m, d, t);
      check_all($sformatf("m%0d d%0d t%0d", m, d, t), e);
      last_code = e.code;
      if (t < n - 1) begin
        if (e.busy == 1 && $urandom_range(3) == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    idle_e = '{code: last_code, valid: 0, busy: 0, wrap: 0, done: 0};
    check_all($sformatf("m%0d d%0d stop", m, d), idle_e);
    $display("scan mode=%0d dwell=%0d cycles=%0d stopped on code %0d", m, d, n, last_code);
  endtask

  initial begin
    vec_t vecs[5];
    exp_t e;
    int lc;
    int m, d, n;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; dwell = '0;

    vecs[0] = '{mode: 0, dwell: 0, ncyc: 17, exp_stop_code: 0};
    vecs[1] = '{mode: 1, dwell: 2, ncyc: 30, exp_stop_code: 6};
    vecs[2] = '{mode: 2, dwell: 1, ncyc: 20, exp_stop_code: 7};
    vecs[3] = '{mode: 3, dwell: 0, ncyc: 20, exp_stop_code: 5};
    vecs[4] = '{mode: 0, dwell: 5, ncyc: 15, exp_stop_code: 2};

    // Reset, then idle for ten cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e = '{code: 0, valid: 0, busy: 0, wrap: 0, done: 0};
    for (int i = 0; i < 10; i++) begin
      check_all($sformatf("reset idle %0d", i), e);
      @(negedge clk);
    end
    $display("reset idle checked");

    // Directed table of scans.
    for (int v = 0; v < 5; v++) begin
      run_seq(vecs[v].mode, vecs[v].dwell, vecs[v].ncyc, lc);
      check($sformatf("vec%0d stop code", v), int'(code_num), vecs[v].exp_stop_code);
    end

    // start and stop together in IDLE: stays idle.
    start = 1'b1; stop = 1'b1; mode = 2'b00; dwell = '0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    e = '{code: 2, valid: 0, busy: 0, wrap: 0, done: 0};
    check_all("start+stop idle", e);
    $display("start+stop in idle checked");

    // Reset in the middle of a scan overrides start and stop.
    start = 1'b1; mode = 2'b00; dwell = DWELL_W'(3);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    e = '{code: 1, valid: 1, busy: 1, wrap: 0, done: 0};
    check_all("pre-reset run", e);
    rst = 1'b1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    e = '{code: 0, valid: 0, busy: 0, wrap: 0, done: 0};
    check_all("mid-run reset", e);
    @(negedge clk);
    check_all("post-reset idle", e);
    $display("mid-run reset checked");

    // Randomised scans against the model.
    for (int r = 0; r < 20; r++) begin
      m = int'($urandom_range(3));
      d = int'($urandom_range(3));
      n = int'($urandom_range(40, 1));
      run_seq(m, d, n, lc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
